// File: rtl/mio_input_responder_if.sv
// MIO bus slice seen by the input responder: CPU-side decode, write path,
// registered read data and the interrupt level.
interface mio_input_responder_if;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output sel, output we, output addr, output wdata,
                    input  rdata, input irq);
    modport slave  (input  sel, input  we, input  addr, input  wdata,
                    output rdata, output irq);
endinterface

// File: rtl/mio_input_responder.sv
// Input-side MIO peripheral: synchronises and debounces switches/buttons,
// latches button rising edges into W1C pending bits, raises a masked irq.

// One debounced input bit: sample history shifted on tick, level accepted
// once every entry agrees and differs from the current debounced value.
module mio_deb_lane #(
    parameter int DEB_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic din,
    output logic db,
    output logic rise
);
    logic [DEB_SAMPLES-1:0] hist;
    logic [DEB_SAMPLES-1:0] hist_n;

    assign hist_n = {hist[DEB_SAMPLES-2:0], din};
    // Rising edge is flagged on the same edge that db flips to 1.
    assign rise   = tick && (&hist_n) && !db;

    // History shift and debounced level update on each sample tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            db   <= 1'b0;
        end else if (tick) begin
            hist <= hist_n;
            if (&hist_n)
                db <= 1'b1;
            else if (~|hist_n)
                db <= 1'b0;
        end
    end
endmodule

module mio_input_responder #(
    parameter logic [15:0] TICK_DIV    = 16'd50000,
    parameter int          DEB_SAMPLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            sw_raw,
    input  logic [4:0]             btn_raw,
    mio_input_responder_if.slave   bus
);
    localparam int NBITS = 21;

    logic [NBITS-1:0] s1, s2;
    logic [NBITS-1:0] db;
    logic [NBITS-1:0] rise;
    logic [15:0]      tcnt;
    logic             tick;
    logic [4:0]       pend, mask;
    logic [4:0]       clr;
    logic [31:0]      rd_mux;
    logic             wr;
    logic             unused_bits;

    assign tick = (tcnt == TICK_DIV - 16'd1);
    assign wr   = bus.sel && bus.we;
    assign unused_bits = ^{rise[15:0], bus.wdata[31:5]};

    // Two-flop synchroniser; buttons occupy the top five bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {btn_raw, sw_raw};
            s2 <= s1;
        end
    end

    // Free-running sample divider, 0..TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (rst)
            tcnt <= '0;
        else if (tick)
            tcnt <= '0;
        else
            tcnt <= tcnt + 16'd1;
    end

    mio_deb_lane #(.DEB_SAMPLES(DEB_SAMPLES)) u_lane [NBITS-1:0] (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .din  (s2),
        .db   (db),
        .rise (rise)
    );

    // Read mux and W1C clear mask; reads see pre-write state.
    always_comb begin
        clr    = '0;
        rd_mux = '0;
        if (wr && bus.addr == 2'd1)
            clr = bus.wdata[4:0];
        case (bus.addr)
            2'd0:    rd_mux = {11'b0, db};
            2'd1:    rd_mux = {27'b0, pend};
            2'd2:    rd_mux = {27'b0, mask};
            default: rd_mux = {16'b0, tcnt};
        endcase
    end

    // Pending/mask registers, registered read data and irq level.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            mask      <= '0;
            bus.rdata <= '0;
            bus.irq   <= 1'b0;
        end else begin
            // A new edge beats a simultaneous clear.
            pend      <= (pend & ~clr) | rise[20:16];
            if (wr && bus.addr == 2'd2)
                mask <= bus.wdata[4:0];
            bus.rdata <= rd_mux;
            bus.irq   <= |(pend & mask);
        end
    end
endmodule

// File: tb/tb_mio_input_responder.sv
module tb_mio_input_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw_raw = '0;
    logic [4:0]  btn_raw = '0;
    logic        chk_req = 1'b0;
    int          ecount = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic        crd;
        logic [31:0] erd;
        logic        cirq;
        logic        eirq;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_it;
    logic mon_take;

    mio_input_responder_if bus ();

    mio_input_responder #(.TICK_DIV(16'd4), .DEB_SAMPLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_raw  (sw_raw),
        .btn_raw (btn_raw),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Edge index since the last reset edge; tick edges are multiples of 4.
    always @(posedge clk) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    // Monitor: an expectation queued for an edge is compared after that edge.
    always begin
        @(posedge clk);
        mon_take = chk_req;
        if (mon_take) begin
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty at ecount=%0d", ecount);
                mon_take = 1'b0;
            end else begin
                mon_it = exp_q.pop_front();
            end
        end
        @(negedge clk);
        if (mon_take) begin
            if (mon_it.crd) begin
                checks++;
                if (bus.rdata !== mon_it.erd) begin
                    failures++;
                    $display("FAIL %s rdata got=%h exp=%h ecount=%0d", mon_it.nm, bus.rdata, mon_it.erd, ecount);
                end
            end
            if (mon_it.cirq) begin
                checks++;
                if (bus.irq !== mon_it.eirq) begin
                    failures++;
                    $display("FAIL %s irq got=%b exp=%b ecount=%0d", mon_it.nm, bus.irq, mon_it.eirq, ecount);
                end
            end
        end
    end

    // One bus cycle: drive at +1 after an edge, optionally queue expectations
    // for the rdata/irq registered on the next edge.
    task automatic op(input logic [1:0] a, input logic s, input logic w, input logic [31:0] wd,
                      input logic crd, input logic [31:0] erd, input logic cirq, input logic eirq,
                      input string nm);
        exp_t it;
        bus.addr  = a;
        bus.sel   = s;
        bus.we    = w;
        bus.wdata = wd;
        if (crd || cirq) begin
            it.crd = crd; it.erd = erd; it.cirq = cirq; it.eirq = eirq; it.nm = nm;
            exp_q.push_back(it);
            chk_req = 1'b1;
        end else begin
            chk_req = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.sel = 1'b0;
        bus.we  = 1'b0;
        chk_req = 1'b0;
    endtask

    task automatic idle();
        op(2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, "idle");
    endtask

    task automatic wait_to(input int e);
        while (ecount < e) idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired ecount=%0d", ecount);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = '0;
        @(posedge clk); #1;
        idle(); idle();
        op(2'd3, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, "reset_state");
        rst = 1'b0;

        // Quiet bus: STATE/PEND/MASK read 0, TICKCNT walks 0..3.
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  a;
            logic [31:0] e;
            a = 2'(i % 4);
            e = (a == 2'd3) ? 32'(ecount % 4) : 32'h0;
            op(a, 1'b0, 1'b0, 32'h0, 1'b1, e, 1'b1, 1'b0, "idle_read");
        end

        // Switch change at edge 20: first tick sample at 24, accepted at 36.
        wait_to(20);
        sw_raw = 16'hA5C3;
        while (ecount < 40)
            op(2'd0, 1'b0, 1'b0, 32'h0, 1'b1, (ecount + 1 > 36) ? 32'h0000A5C3 : 32'h0,
               1'b0, 1'b0, "sw_debounce");

        // Two-tick glitch on btn[2] must never reach STATE or PEND.
        btn_raw[2] = 1'b1;
        while (ecount < 64) begin
            if (ecount == 48) btn_raw[2] = 1'b0;
            if (ecount % 2 == 0)
                op(2'd0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000A5C3, 1'b0, 1'b0, "glitch_state");
            else
                op(2'd1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, "glitch_pend");
        end

        // btn[0] held with mask bit 0: PEND then irq, then W1C clears both.
        op(2'd2, 1'b1, 1'b1, 32'hFFFF_FFE1, 1'b0, 32'h0, 1'b0, 1'b0, "mask_wr");
        op(2'd2, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1, 1'b0, 1'b0, "mask_rd");
        wait_to(68);
        btn_raw[0] = 1'b1;
        while (ecount < 90)
            op(2'd1, 1'b0, 1'b0, 32'h0, 1'b1, (ecount + 1 > 84) ? 32'h1 : 32'h0,
               1'b1, (ecount + 1 > 84), "btn0_pend_irq");
        op(2'd1, 1'b1, 1'b1, 32'h1, 1'b1, 32'h1, 1'b1, 1'b1, "w1c_prewrite");
        op(2'd1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, "w1c_cleared");
        op(2'd0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0001A5C3, 1'b1, 1'b0, "state_btn0");

        // btn[3] rises on edge 112; W1C of bit 3 on that same edge loses.
        op(2'd2, 1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0, "mask_wr3");
        wait_to(96);
        btn_raw[3] = 1'b1;
        wait_to(111);
        op(2'd1, 1'b1, 1'b1, 32'h8, 1'b1, 32'h0, 1'b1, 1'b0, "set_vs_clr_edge");
        op(2'd1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 1'b1, "set_wins");

        // btn[1] partially debounced (two samples), then reset.
        wait_to(116);
        btn_raw[1] = 1'b1;
        wait_to(126);
        rst = 1'b1;
        op(2'd1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, "rst_mid");
        rst = 1'b0;
        // All held inputs re-debounce from empty history: accepted at edge 16.
        while (ecount < 20)
            op(2'd0, 1'b0, 1'b0, 32'h0, 1'b1, (ecount + 1 > 16) ? 32'h000BA5C3 : 32'h0,
               1'b1, 1'b0, "redebounce");
        op(2'd1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hB, 1'b1, 1'b0, "redeb_pend");
        op(2'd2, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, "redeb_mask");

        idle(); idle();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
